// File: rtl/fp_pkg.sv
// Shared types for the FP issue/writeback controller: tag table entry,
// controller state and writeback-source select.
package fp_pkg;

   localparam int unsigned FP_NREG = 32;
   localparam int unsigned FP_AW   = 5;

   typedef struct packed {
      logic [FP_AW-1:0] rd;
      logic             fp_wr;
      logic             int_wr;
   } fp_issue_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fp_issue_state_e;

   typedef enum logic {
      WB_FPU  = 1'b0,
      WB_LOAD = 1'b1
   } fp_wb_sel_e;

   function automatic logic [FP_NREG-1:0] fp_onehot(
      input logic             en,
      input logic [FP_AW-1:0] addr
   );
      return en ? (FP_NREG'(1) << addr) : '0;
   endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register pending bits for the FP regfile with RAW/WAW lookup.
// Ports: clk_i/rst_ni; set0/set1 (issue, load alloc) and clr0/clr1
// (FPU wb, load wb) address ports; rs_i/rs_used_i/rd_i/rd_chk_i lookup;
// wb_en_i/wb_addr_i is the regfile write currently in progress;
// hazard_o stall request; any_pending_o when any bit is set.
module fp_scoreboard
   import fp_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 set0_en_i,
   input  logic [FP_AW-1:0]     set0_addr_i,
   input  logic                 set1_en_i,
   input  logic [FP_AW-1:0]     set1_addr_i,
   input  logic                 clr0_en_i,
   input  logic [FP_AW-1:0]     clr0_addr_i,
   input  logic                 clr1_en_i,
   input  logic [FP_AW-1:0]     clr1_addr_i,
   input  logic [3*FP_AW-1:0]   rs_i,
   input  logic [2:0]           rs_used_i,
   input  logic [FP_AW-1:0]     rd_i,
   input  logic                 rd_chk_i,
   input  logic                 wb_en_i,
   input  logic [FP_AW-1:0]     wb_addr_i,
   output logic                 hazard_o,
   output logic                 any_pending_o
);

   logic [FP_NREG-1:0] pend_q;
   logic [FP_NREG-1:0] pend_d;
   logic [FP_NREG-1:0] set_m;
   logic [FP_NREG-1:0] clr_m;

   assign set_m = fp_onehot(set0_en_i, set0_addr_i)
                | fp_onehot(set1_en_i, set1_addr_i);
   assign clr_m = fp_onehot(clr0_en_i, clr0_addr_i)
                | fp_onehot(clr1_en_i, clr1_addr_i);

   // A new allocation of a register wins over a completing write.
   assign pend_d = (pend_q & ~clr_m) | set_m;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // The bit clears at the handshake edge, but the regfile is only
   // written at the end of the following cycle; with no bypass a reader
   // must also wait out the write in progress.
   always_comb begin
      logic [FP_AW-1:0] a;
      hazard_o = rd_chk_i & pend_q[rd_i];
      for (int i = 0; i < 3; i++) begin
         a = rs_i[i*FP_AW +: FP_AW];
         if (rs_used_i[i] &&
             (pend_q[a] || (wb_en_i && (wb_addr_i == a)))) begin
            hazard_o = 1'b1;
         end
      end
   end

   assign any_pending_o = |pend_q;

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: scoreboarded issue to FPnew, tag table,
// single regfile write port shared by FPU results and FLW returns,
// flush/drain FSM. Ports: dec_* decode side, fpu_* FPU handshakes,
// ld_* load alloc/return, fprf_*/int_wb_* registered writebacks,
// flush_i, busy_o. FP_ISSUE_PERF_CNT_EN adds perf_issue_o/perf_stall_o.
module fp_issue_ctrl
   import fp_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter bit LOAD_PRIO       = 1'b1,
   localparam int TAG_W          = $clog2(MAX_OUTSTANDING)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dec_valid_i,
   output logic             dec_ready_o,
   input  logic [14:0]      dec_rs_i,
   input  logic [2:0]       dec_rs_used_i,
   input  logic [4:0]       dec_rd_i,
   input  logic             dec_fp_wr_i,
   input  logic             dec_int_wr_i,
   output logic             fpu_in_valid_o,
   input  logic             fpu_in_ready_i,
   output logic [TAG_W-1:0] fpu_tag_o,
   input  logic             fpu_out_valid_i,
   output logic             fpu_out_ready_o,
   input  logic [TAG_W-1:0] fpu_tag_i,
   input  logic             ld_alloc_i,
   input  logic [4:0]       ld_alloc_rd_i,
   input  logic             ld_valid_i,
   input  logic [4:0]       ld_rd_i,
   output logic             ld_ready_o,
   output logic             fprf_we_o,
   output logic [4:0]       fprf_waddr_o,
   output logic             fprf_wsel_o,
   output logic             int_wb_valid_o,
   output logic [4:0]       int_wb_rd_o,
   input  logic             flush_i,
`ifdef FP_ISSUE_PERF_CNT_EN
   output logic [31:0]      perf_issue_o,
   output logic [31:0]      perf_stall_o,
`endif
   output logic             busy_o
);

   localparam logic [TAG_W:0] MAX_CNT = (TAG_W+1)'(MAX_OUTSTANDING);

   fp_issue_state_e state_q;
   fp_issue_state_e state_d;
   logic [TAG_W:0]   cnt_q;
   logic [TAG_W-1:0] tag_q;
   fp_issue_entry_t  tbl_q [MAX_OUTSTANDING];
   fp_issue_entry_t  res_e;
   fp_wb_sel_e       wsel_q;

   logic hazard;
   logic any_pend;
   logic collide;
   logic iss_hs;
   logic res_hs;
   logic ld_hs;

   assign collide = fpu_out_valid_i & ld_valid_i;

   // Only the arbitration loser drops ready; it retries next cycle.
   assign fpu_out_ready_o = !(collide && LOAD_PRIO);
   assign ld_ready_o      = !(collide && !LOAD_PRIO);

   assign res_hs = fpu_out_valid_i & fpu_out_ready_o;
   assign ld_hs  = ld_valid_i & ld_ready_o;
   assign res_e  = tbl_q[fpu_tag_i];

   assign fpu_in_valid_o = dec_valid_i & !hazard
                         & (cnt_q < MAX_CNT)
                         & (state_q == RUN);
   assign dec_ready_o    = fpu_in_valid_o & fpu_in_ready_i;
   assign iss_hs         = dec_ready_o;
   assign fpu_tag_o      = tag_q;
   assign busy_o         = (cnt_q != '0) | (state_q != RUN);
   assign fprf_wsel_o    = wsel_q;

   fp_scoreboard u_sb (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .set0_en_i     (iss_hs & dec_fp_wr_i),
      .set0_addr_i   (dec_rd_i),
      .set1_en_i     (ld_alloc_i),
      .set1_addr_i   (ld_alloc_rd_i),
      .clr0_en_i     (res_hs & res_e.fp_wr),
      .clr0_addr_i   (res_e.rd),
      .clr1_en_i     (ld_hs),
      .clr1_addr_i   (ld_rd_i),
      .rs_i          (dec_rs_i),
      .rs_used_i     (dec_rs_used_i),
      .rd_i          (dec_rd_i),
      .rd_chk_i      (dec_fp_wr_i),
      .wb_en_i       (fprf_we_o),
      .wb_addr_i     (fprf_waddr_o),
      .hazard_o      (hazard),
      .any_pending_o (any_pend)
   );

   // With no FPU op in flight, any remaining pending bit is a load.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (flush_i) state_d = DRAIN;
         DRAIN:   if ((cnt_q == '0) && !any_pend) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         cnt_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         if (iss_hs && !res_hs) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!iss_hs && res_hs) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (iss_hs) begin
            tag_q <= tag_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tbl_q[i] <= '0;
         end
      end else if (iss_hs) begin
         tbl_q[tag_q] <= '{rd: dec_rd_i,
                           fp_wr: dec_fp_wr_i,
                           int_wr: dec_int_wr_i};
      end
   end

   // Load and FPU handshakes are mutually exclusive by arbitration.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fprf_we_o      <= 1'b0;
         fprf_waddr_o   <= '0;
         wsel_q         <= WB_FPU;
         int_wb_valid_o <= 1'b0;
         int_wb_rd_o    <= '0;
      end else if (ld_hs) begin
         fprf_we_o      <= 1'b1;
         fprf_waddr_o   <= ld_rd_i;
         wsel_q         <= WB_LOAD;
         int_wb_valid_o <= 1'b0;
         int_wb_rd_o    <= '0;
      end else if (res_hs) begin
         fprf_we_o      <= res_e.fp_wr;
         fprf_waddr_o   <= res_e.rd;
         wsel_q         <= WB_FPU;
         int_wb_valid_o <= res_e.int_wr;
         int_wb_rd_o    <= res_e.rd;
      end else begin
         fprf_we_o      <= 1'b0;
         fprf_waddr_o   <= '0;
         wsel_q         <= WB_FPU;
         int_wb_valid_o <= 1'b0;
         int_wb_rd_o    <= '0;
      end
   end

`ifdef FP_ISSUE_PERF_CNT_EN
   logic [31:0] perf_issue_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (iss_hs) begin
            perf_issue_q <= perf_issue_q + 32'd1;
         end
         if (dec_valid_i && !dec_ready_o) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_issue_o = perf_issue_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl (MAX_OUTSTANDING=4, LOAD_PRIO=1).
// Covers hazards, tag wrap, collision, drain and async reset.
module tb_fp_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [14:0] dec_rs;
   logic [2:0]  dec_rs_used;
   logic [4:0]  dec_rd;
   logic        dec_fp_wr;
   logic        dec_int_wr;
   logic        fpu_in_valid;
   logic        fpu_in_ready;
   logic [1:0]  fpu_tag_o;
   logic        fpu_out_valid;
   logic        fpu_out_ready;
   logic [1:0]  fpu_tag;
   logic        ld_alloc;
   logic [4:0]  ld_alloc_rd;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic        ld_ready;
   logic        fprf_we;
   logic [4:0]  fprf_waddr;
   logic        fprf_wsel;
   logic        int_wb_valid;
   logic [4:0]  int_wb_rd;
   logic        flush;
   logic        busy;
`ifdef FP_ISSUE_PERF_CNT_EN
   logic [31:0] perf_issue;
   logic [31:0] perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_issue_ctrl #(
      .MAX_OUTSTANDING (4),
      .LOAD_PRIO       (1'b1)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .dec_valid_i     (dec_valid),
      .dec_ready_o     (dec_ready),
      .dec_rs_i        (dec_rs),
      .dec_rs_used_i   (dec_rs_used),
      .dec_rd_i        (dec_rd),
      .dec_fp_wr_i     (dec_fp_wr),
      .dec_int_wr_i    (dec_int_wr),
      .fpu_in_valid_o  (fpu_in_valid),
      .fpu_in_ready_i  (fpu_in_ready),
      .fpu_tag_o       (fpu_tag_o),
      .fpu_out_valid_i (fpu_out_valid),
      .fpu_out_ready_o (fpu_out_ready),
      .fpu_tag_i       (fpu_tag),
      .ld_alloc_i      (ld_alloc),
      .ld_alloc_rd_i   (ld_alloc_rd),
      .ld_valid_i      (ld_valid),
      .ld_rd_i         (ld_rd),
      .ld_ready_o      (ld_ready),
      .fprf_we_o       (fprf_we),
      .fprf_waddr_o    (fprf_waddr),
      .fprf_wsel_o     (fprf_wsel),
      .int_wb_valid_o  (int_wb_valid),
      .int_wb_rd_o     (int_wb_rd),
      .flush_i         (flush),
`ifdef FP_ISSUE_PERF_CNT_EN
      .perf_issue_o    (perf_issue),
      .perf_stall_o    (perf_stall),
`endif
      .busy_o          (busy)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_valid     = 1'b0;
      dec_rs        = '0;
      dec_rs_used   = '0;
      dec_rd        = '0;
      dec_fp_wr     = 1'b0;
      dec_int_wr    = 1'b0;
      fpu_in_ready  = 1'b1;
      fpu_out_valid = 1'b0;
      fpu_tag       = '0;
      ld_alloc      = 1'b0;
      ld_alloc_rd   = '0;
      ld_valid      = 1'b0;
      ld_rd         = '0;
      flush         = 1'b0;
   endtask

   task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rs3, input logic [2:0] used,
                      input logic [4:0] rd, input logic fpw,
                      input logic intw);
      dec_valid   = 1'b1;
      dec_rs      = {rs3, rs2, rs1};
      dec_rs_used = used;
      dec_rd      = rd;
      dec_fp_wr   = fpw;
      dec_int_wr  = intw;
   endtask

   task automatic ret(input logic [1:0] t);
      fpu_out_valid = 1'b1;
      fpu_tag       = t;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      check("rst_we", fprf_we, 0);
      check("rst_int", int_wb_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_fiv", fpu_in_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // FADD f3<-f1,f2 then FMUL f4<-f3,f5
      dec(1, 2, 0, 3'b011, 3, 1, 0);
      #1;
      check("a_fadd_rdy", dec_ready, 1);
      check("a_fadd_tag", fpu_tag_o, 0);
      tick();
      dec(0, 0, 0, 3'b000, 3, 1, 0);
      #1;
      check("a_waw", dec_ready, 0);
      tick();
      dec(3, 5, 0, 3'b011, 4, 1, 0);
      #1;
      check("a_raw", dec_ready, 0);
      check("a_busy", busy, 1);
      tick();
      ret(0);
      #1;
      check("a_res_rdy", fpu_out_ready, 1);
      check("a_raw2", dec_ready, 0);
      tick();
      fpu_out_valid = 1'b0;
      #1;
      check("a_we", fprf_we, 1);
      check("a_waddr", fprf_waddr, 3);
      check("a_wsel", fprf_wsel, 0);
      check("a_nobyp", dec_ready, 0);
      tick();
      #1;
      check("a_we_off", fprf_we, 0);
      check("a_fmul_rdy", dec_ready, 1);
      check("a_fmul_tag", fpu_tag_o, 1);
      tick();
      dec_valid = 1'b0;
      ret(1);
      tick();
      fpu_out_valid = 1'b0;
      #1;
      check("a_we2", fprf_we, 1);
      check("a_waddr2", fprf_waddr, 4);
      check("a_busy0", busy, 0);
      tick();

      // 5 independent ops, FPU out held off
      do_reset();
      for (int i = 0; i < 4; i++) begin
         dec(0, 0, 0, 3'b000, 5'(10 + i), 1, 0);
         #1;
         check("b_rdy", dec_ready, 1);
         check("b_tag", fpu_tag_o, i);
         tick();
      end
      dec(0, 0, 0, 3'b000, 14, 1, 0);
      #1;
      check("b_full_rdy", dec_ready, 0);
      check("b_full_fiv", fpu_in_valid, 0);
      tick();
      #1;
      check("b_full_rdy2", dec_ready, 0);
      tick();
`ifdef FP_ISSUE_PERF_CNT_EN
      check("b_perf_iss", perf_issue, 4);
      check("b_perf_stall", perf_stall, 2);
`endif
      dec_valid = 1'b0;

      // tag 2 result collides with f7 load return
      ld_alloc    = 1'b1;
      ld_alloc_rd = 7;
      tick();
      ld_alloc = 1'b0;
      ret(2);
      ld_valid = 1'b1;
      ld_rd    = 7;
      #1;
      check("c_fo_rdy", fpu_out_ready, 0);
      check("c_ld_rdy", ld_ready, 1);
      tick();
      ld_valid = 1'b0;
      #1;
      check("c_ld_we", fprf_we, 1);
      check("c_ld_addr", fprf_waddr, 7);
      check("c_ld_sel", fprf_wsel, 1);
      check("c_fo_rdy2", fpu_out_ready, 1);
      tick();
      fpu_out_valid = 1'b0;
      #1;
      check("c_fp_we", fprf_we, 1);
      check("c_fp_addr", fprf_waddr, 12);
      check("c_fp_sel", fprf_wsel, 0);
      ret(0);
      tick();
      ret(1);
      tick();
      ret(3);
      tick();
      fpu_out_valid = 1'b0;
      #1;
      check("c_last_addr", fprf_waddr, 13);
      check("c_busy0", busy, 0);
      tick();

      // flush with 3 in flight
      for (int i = 0; i < 3; i++) begin
         dec(0, 0, 0, 3'b000, 5'(1 + i), 1, 0);
         tick();
      end
      dec_valid = 1'b0;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      dec(0, 0, 0, 3'b000, 9, 1, 0);
      #1;
      check("d_rdy", dec_ready, 0);
      check("d_fiv", fpu_in_valid, 0);
      check("d_busy", busy, 1);
      for (int i = 0; i < 3; i++) begin
         ret(2'(i));
         #1;
         check("d_drain_rdy", dec_ready, 0);
         tick();
      end
      fpu_out_valid = 1'b0;
      #1;
      check("d_last_rdy", dec_ready, 0);
      check("d_last_busy", busy, 1);
      tick();
      #1;
      check("d_run_rdy", dec_ready, 1);
      check("d_run_busy", busy, 0);
      check("d_run_tag", fpu_tag_o, 3);
      tick();
      dec_valid = 1'b0;
      ret(3);
      tick();
      fpu_out_valid = 1'b0;

      // async reset with 2 in flight and a write in progress
      dec(0, 0, 0, 3'b000, 5, 1, 0);
      tick();
      dec(0, 0, 0, 3'b000, 6, 1, 0);
      tick();
      dec_valid = 1'b0;
      ret(0);
      tick();
      fpu_out_valid = 1'b0;
      #1;
      check("f_pre_we", fprf_we, 1);
      check("f_pre_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("f_we", fprf_we, 0);
      check("f_waddr", fprf_waddr, 0);
      check("f_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // FCVT.W.S x10 <- f5 after reset
      dec(5, 0, 0, 3'b001, 10, 0, 1);
      #1;
      check("e_rdy", dec_ready, 1);
      check("e_tag", fpu_tag_o, 0);
      tick();
      dec_valid = 1'b0;
      ret(0);
      tick();
      fpu_out_valid = 1'b0;
      dec(10, 0, 0, 3'b001, 11, 1, 0);
      #1;
      check("e_int_v", int_wb_valid, 1);
      check("e_int_rd", int_wb_rd, 10);
      check("e_we", fprf_we, 0);
      check("e_nopend", dec_ready, 1);
      tick();
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
